mealy_seq_detector: RTL and testbench

//   Parametrised Mealy serial-pattern detector; generalises the fixed 2-state "11" detector.

---
 rtl/seq_det_pkg.sv | 112 +++++++++++
 rtl/mealy_seq_detector_if.sv | 34 +++
 rtl/seq_det_sat_cnt.sv | 40 ++++
 rtl/mealy_seq_detector.sv | 93 +++++++++
 tb/tb_mealy_seq_detector.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seq_det_pkg
// Description : Elaboration-time helpers for mealy_seq_detector.
//               - clog2 and state-width derivation (ST_W = clog2(PAT_LEN), min 1)
//               - KMP failure table and full transition table, both built by
//                 constant functions; the detector holds no runtime table
//               - legal-range predicates for PAT_LEN, PATTERN and CNT_W
//               Pattern bit i (i = 0 is received first) is PATTERN[PAT_LEN-1-i].
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  localparam int MAX_PAT_LEN = 16;
  localparam int ENTRY_W     = 4;                          // holds a state 0..15
  localparam int TBL_W       = 2 * MAX_PAT_LEN * ENTRY_W;  // (state, bit) -> next
  localparam int FAIL_W      = (MAX_PAT_LEN + 1) * ENTRY_W;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // State register width: enough for 0..PAT_LEN-1, never below one bit.
  function automatic int st_width(input int len);
    return (clog2(len) < 1) ? 1 : clog2(len);
  endfunction

  function automatic bit pat_len_ok(input int len);
    return (len >= 2) && (len <= MAX_PAT_LEN);
  endfunction

  // Bits above PAT_LEN must be zero so the pattern is unambiguous.
  function automatic bit pattern_ok(input logic [MAX_PAT_LEN-1:0] pat, input int len);
    if (len >= MAX_PAT_LEN) return 1'b1;
    return (pat >> len) == '0;
  endfunction

  function automatic bit cnt_w_ok(input int w);
    return (w >= 1) && (w <= 32);
  endfunction

  function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pat, input int len,
                                   input int i);
    return pat[len-1-i];
  endfunction

  // One bit per state encoding: set for reachable states 0..len-1.
  function automatic logic [MAX_PAT_LEN-1:0] valid_mask(input int len);
    logic [MAX_PAT_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PAT_LEN; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

  // f[q] (q = 1..len): longest proper prefix of the first q pattern bits that
  // is also a suffix of them. Entry q lives at bits [q*ENTRY_W +: ENTRY_W].
  function automatic logic [FAIL_W-1:0] kmp_fail(input logic [MAX_PAT_LEN-1:0] pat,
                                                 input int len);
    logic [FAIL_W-1:0] f;
    int                k;
    f = '0;
    k = 0;
    if (pat_len_ok(len)) begin
      for (int q = 1; q < len; q++) begin
        while ((k > 0) && (pat_bit(pat, len, k) != pat_bit(pat, len, q)))
          k = int'(f[k*ENTRY_W +: ENTRY_W]);
        if (pat_bit(pat, len, k) == pat_bit(pat, len, q)) k++;
        f[(q+1)*ENTRY_W +: ENTRY_W] = ENTRY_W'(k);
      end
    end
    return f;
  endfunction

  // Complete Mealy transition table. Entry for (state k, bit b) is at
  // bits [(2*k+b)*ENTRY_W +: ENTRY_W]; unreachable states map to 0.
  function automatic logic [TBL_W-1:0] build_next(input logic [MAX_PAT_LEN-1:0] pat,
                                                  input int len, input bit overlap);
    logic [TBL_W-1:0]  t;
    logic [FAIL_W-1:0] f;
    logic              b;
    int                j;
    int                nk;
    t = '0;
    f = kmp_fail(pat, len);
    if (pat_len_ok(len)) begin
      for (int k = 0; k < len; k++) begin
        for (int bi = 0; bi < 2; bi++) begin
          b = 1'(bi);
          if (pat_bit(pat, len, k) == b) begin
            if (k == len - 1) nk = overlap ? int'(f[len*ENTRY_W +: ENTRY_W]) : 0;
            else              nk = k + 1;
          end else begin
            j = (k == 0) ? 0 : int'(f[k*ENTRY_W +: ENTRY_W]);
            while ((j > 0) && (pat_bit(pat, len, j) != b))
              j = int'(f[j*ENTRY_W +: ENTRY_W]);
            nk = (pat_bit(pat, len, j) == b) ? j + 1 : 0;
          end
          t[(2*k+bi)*ENTRY_W +: ENTRY_W] = ENTRY_W'(nk);
        end
      end
    end
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mealy_seq_detector_if.sv
`default_nettype none
// ============================================================================
// Interface   : mealy_seq_detector_if
// Description : Serial-sample and match signals of mealy_seq_detector.
//               master: sample source / match consumer; slave: the detector.
//   en        sample valid           clr      clear match progress (and count)
//   in        serial data bit        out      Mealy match pulse (combinational)
//   curr_st   matched-prefix length  match_cnt saturating match count
// Macros      : SEQ_DET_MATCH_CNT_EN - adds CNT_W parameter and match_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface mealy_seq_detector_if #(
  parameter int ST_W = 2
`ifdef SEQ_DET_MATCH_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic            en;
  logic            clr;
  logic            in;
  logic            out;
  logic [ST_W-1:0] curr_st;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;

  modport master (output en, clr, in, input  out, curr_st, match_cnt);
  modport slave  (input  en, clr, in, output out, curr_st, match_cnt);
`else
  modport master (output en, clr, in, input  out, curr_st);
  modport slave  (input  en, clr, in, output out, curr_st);
`endif
endinterface
`default_nettype wire

// File: rtl/seq_det_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_sat_cnt
// Description : CNT_W-bit saturating up-counter with synchronous clear.
//   clk     in  clock, rising edge
//   resetn  in  asynchronous active-low reset (count -> 0)
//   inc_i   in  add one unless already at all-ones
//   clr_i   in  synchronous clear, wins over inc_i
//   cnt_o   out current count
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  input  wire logic             inc_i,
  input  wire logic             clr_i,
  output logic      [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (inc_i && (cnt_q != '1))  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mealy_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : mealy_seq_detector
// Description : Parametrised Mealy serial-pattern detector with overlap and
//               sample enable. State k = number of pattern bits already
//               matched (0..PAT_LEN-1); out fires combinationally in the
//               cycle the final pattern bit is presented.
//   clk     in  clock, rising edge
//   resetn  in  asynchronous active-low reset
//   bus     slave modport of mealy_seq_detector_if (en, clr, in, out,
//           curr_st, match_cnt)
// Parameters  : PAT_LEN (2..16), PATTERN (MSB of the used field first),
//               OVERLAP (1: matches may share bits), CNT_W (counter width)
// Macros      : SEQ_DET_MATCH_CNT_EN - instantiates the saturating match
//               counter driving bus.match_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                     PAT_LEN = 4,
  parameter logic [MAX_PAT_LEN-1:0] PATTERN = 16'b1011,
  parameter bit                     OVERLAP = 1'b1,
  parameter int                     CNT_W   = 8
) (
  input wire logic             clk,
  input wire logic             resetn,
  mealy_seq_detector_if.slave  bus
);

  localparam int                     ST_W       = st_width(PAT_LEN);
  localparam logic [ST_W-1:0]        LAST_ST    = ST_W'(PAT_LEN - 1);
  localparam logic [TBL_W-1:0]       NEXT_TBL   = build_next(PATTERN, PAT_LEN, OVERLAP);
  localparam logic [MAX_PAT_LEN-1:0] VALID_MASK = valid_mask(PAT_LEN);

  // --------------------------------------------------------------------------
  // Elaboration-time legality checks
  // --------------------------------------------------------------------------
  if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
    $fatal(1, "mealy_seq_detector: PAT_LEN=%0d outside 2..16", PAT_LEN);
  end
  if (!pattern_ok(PATTERN, PAT_LEN)) begin : g_bad_pattern
    $fatal(1, "mealy_seq_detector: PATTERN has bits set above PAT_LEN");
  end
  if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
    $fatal(1, "mealy_seq_detector: CNT_W=%0d outside 1..32", CNT_W);
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  logic            match;
  logic [6:0]      tbl_bit;   // bit offset of (state, in) entry in NEXT_TBL

  always_comb begin
    // Holding is the default; an unreachable encoding falls back to 0 even
    // when no sample is accepted.
    state_d = VALID_MASK[4'(state_q)] ? state_q : '0;
    match   = 1'b0;
    tbl_bit = 7'({state_q, bus.in, 2'b00});
    if (bus.clr) begin
      state_d = '0;
    end else if (bus.en) begin
      state_d = ST_W'(NEXT_TBL[tbl_bit +: ENTRY_W]);
      match   = (state_q == LAST_ST) && (bus.in == PATTERN[0]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= '0;
    else         state_q <= state_d;
  end

  assign bus.out     = match;
  assign bus.curr_st = state_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  // match already excludes clr, so the counter never sees both at once.
  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc_i  (match),
    .clr_i  (bus.clr),
    .cnt_o  (bus.match_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mealy_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mealy_seq_detector
// Description : Self-checking bench. Three detectors share one stimulus:
//               A = 1011 overlap, B = 1011 no overlap, C = legacy "11".
//               Inputs change 1 time unit after the rising edge; out is
//               sampled on the falling edge, curr_st 1 unit after the edge.
// Macros      : SEQ_DET_MATCH_CNT_EN - enables the match-counter scenario
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_seq_detector;

  logic clk = 1'b0;
  logic resetn;
  logic en;
  logic clr;
  logic din;

  int n_checks = 0;
  int n_pass   = 0;

  // Values captured by send()
  logic       o_a, o_b, o_c;
  logic [1:0] st_a, st_b;
  logic       st_c;

  always #5 clk = ~clk;

  mealy_seq_detector_if #(
    .ST_W (2)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .CNT_W (2)
`endif
  ) if_a ();
  mealy_seq_detector_if #(.ST_W(2)) if_b ();
  mealy_seq_detector_if #(.ST_W(1)) if_c ();

  assign if_a.en = en;  assign if_a.clr = clr;  assign if_a.in = din;
  assign if_b.en = en;  assign if_b.clr = clr;  assign if_b.in = din;
  assign if_c.en = en;  assign if_c.clr = clr;  assign if_c.in = din;

  mealy_seq_detector #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b1), .CNT_W(2))
    u_dut_a (.clk(clk), .resetn(resetn), .bus(if_a.slave));
  mealy_seq_detector #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1'b0), .CNT_W(8))
    u_dut_b (.clk(clk), .resetn(resetn), .bus(if_b.slave));
  mealy_seq_detector #(.PAT_LEN(2), .PATTERN(16'b11),   .OVERLAP(1'b1), .CNT_W(8))
    u_dut_c (.clk(clk), .resetn(resetn), .bus(if_c.slave));

  // One sample: drive, capture out mid-cycle, capture state after the edge.
  task automatic send(input logic e, input logic c, input logic b);
    en = e; clr = c; din = b;
    @(negedge clk);
    o_a = if_a.out; o_b = if_b.out; o_c = if_c.out;
    @(posedge clk);
    #1;
    st_a = if_a.curr_st; st_b = if_b.curr_st; st_c = if_c.curr_st;
  endtask

  task automatic clear_all();
    send(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b1; en = 1'b0; clr = 1'b0; din = 1'b0;
    #1 resetn = 1'b0; en = 1'b1; din = 1'b1;
    #2;
    n_checks++; if (if_a.curr_st !== 2'd0) $display("FAIL reset_st_a: got %0d want 0", if_a.curr_st); else n_pass++;
    n_checks++; if (if_b.curr_st !== 2'd0) $display("FAIL reset_st_b: got %0d want 0", if_b.curr_st); else n_pass++;
    n_checks++; if (if_c.curr_st !== 1'd0) $display("FAIL reset_st_c: got %0d want 0", if_c.curr_st); else n_pass++;
    n_checks++; if (if_a.out !== 1'b0) $display("FAIL reset_out_a: got %b want 0", if_a.out); else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (if_a.curr_st !== 2'd0) $display("FAIL reset_hold_st_a: got %0d want 0", if_a.curr_st); else n_pass++;
`ifdef SEQ_DET_MATCH_CNT_EN
    n_checks++; if (if_a.match_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", if_a.match_cnt); else n_pass++;
`endif
    @(negedge clk) resetn = 1'b1; en = 1'b0; din = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_overlap();
    logic [6:0] stream  = 7'b1011011;
    logic [6:0] exp_out = 7'b0001001;
    int         exp_st[7] = '{1, 2, 3, 1, 2, 3, 1};
    clear_all();
    for (int i = 0; i < 7; i++) begin
      send(1'b1, 1'b0, stream[6-i]);
      n_checks++; if (o_a !== exp_out[6-i]) $display("FAIL ovl_out bit%0d: got %b want %b", i+1, o_a, exp_out[6-i]); else n_pass++;
      n_checks++; if (st_a !== 2'(exp_st[i])) $display("FAIL ovl_st bit%0d: got %0d want %0d", i+1, st_a, exp_st[i]); else n_pass++;
    end
  endtask

  task automatic test_no_overlap();
    logic [6:0] stream  = 7'b1011011;
    logic [6:0] exp_out = 7'b0001000;
    int         exp_st[7] = '{1, 2, 3, 0, 0, 1, 1};
    clear_all();
    for (int i = 0; i < 7; i++) begin
      send(1'b1, 1'b0, stream[6-i]);
      n_checks++; if (o_b !== exp_out[6-i]) $display("FAIL novl_out bit%0d: got %b want %b", i+1, o_b, exp_out[6-i]); else n_pass++;
      n_checks++; if (st_b !== 2'(exp_st[i])) $display("FAIL novl_st bit%0d: got %0d want %0d", i+1, st_b, exp_st[i]); else n_pass++;
    end
  endtask

  task automatic test_legacy_11();
    logic [3:0] stream  = 4'b0111;
    logic [3:0] exp_out = 4'b0011;
    logic [3:0] exp_st  = 4'b0111;
    clear_all();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0, stream[3-i]);
      n_checks++; if (o_c !== exp_out[3-i]) $display("FAIL p11_out bit%0d: got %b want %b", i+1, o_c, exp_out[3-i]); else n_pass++;
      n_checks++; if (st_c !== exp_st[3-i]) $display("FAIL p11_st bit%0d: got %0d want %0d", i+1, st_c, exp_st[3-i]); else n_pass++;
    end
  endtask

  task automatic test_enable_gap();
    clear_all();
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_a !== 1'b0) $display("FAIL gap1_out: got %b want 0", o_a); else n_pass++;
    send(1'b0, 1'b0, 1'b1);
    n_checks++; if (o_a !== 1'b0) $display("FAIL gap2_out: got %b want 0", o_a); else n_pass++;
    n_checks++; if (st_a !== 2'd3) $display("FAIL gap_hold_st: got %0d want 3", st_a); else n_pass++;
    send(1'b1, 1'b0, 1'b1);
    n_checks++; if (o_a !== 1'b1) $display("FAIL gap_final_out: got %b want 1", o_a); else n_pass++;
    n_checks++; if (st_a !== 2'd1) $display("FAIL gap_final_st: got %0d want 1", st_a); else n_pass++;
  endtask

  task automatic test_clr_and_async_reset();
    clear_all();
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b1);   // clr wins over a would-be match
    n_checks++; if (o_a !== 1'b0) $display("FAIL clr_out: got %b want 0", o_a); else n_pass++;
    n_checks++; if (st_a !== 2'd0) $display("FAIL clr_st: got %0d want 0", st_a); else n_pass++;
    send(1'b1, 1'b0, 1'b1);
    n_checks++; if (o_a !== 1'b0) $display("FAIL post_clr_out: got %b want 0", o_a); else n_pass++;
    n_checks++; if (st_a !== 2'd1) $display("FAIL post_clr_st: got %0d want 1", st_a); else n_pass++;

    clear_all();
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    en = 1'b1; clr = 1'b0; din = 1'b1;
    #1;
    n_checks++; if (if_a.out !== 1'b1) $display("FAIL pre_rst_out: got %b want 1", if_a.out); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if (if_a.curr_st !== 2'd0) $display("FAIL async_rst_st: got %0d want 0", if_a.curr_st); else n_pass++;
    n_checks++; if (if_a.out !== 1'b0) $display("FAIL async_rst_out: got %b want 0", if_a.out); else n_pass++;
    en = 1'b0; din = 1'b0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef SEQ_DET_MATCH_CNT_EN
  task automatic test_match_cnt();
    logic [18:0] stream = 19'b1011011011011011011;
    int          m = 0;
    int          exp_cnt;
    clear_all();
    for (int i = 0; i < 19; i++) begin
      send(1'b1, 1'b0, stream[18-i]);
      if ((i >= 3) && (((i - 3) % 3) == 0)) begin
        m++;
        exp_cnt = (m > 3) ? 3 : m;
        n_checks++; if (o_a !== 1'b1) $display("FAIL cnt_match_out %0d: got %b want 1", m, o_a); else n_pass++;
        n_checks++; if (if_a.match_cnt !== 2'(exp_cnt)) $display("FAIL cnt_value %0d: got %0d want %0d", m, if_a.match_cnt, exp_cnt); else n_pass++;
      end
    end
    clear_all();
    n_checks++; if (if_a.match_cnt !== 2'd0) $display("FAIL cnt_clr: got %0d want 0", if_a.match_cnt); else n_pass++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_legacy_11();
    test_enable_gap();
    test_clr_and_async_reset();
`ifdef SEQ_DET_MATCH_CNT_EN
    test_match_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
